// File: rtl/vsm_out_port.sv
// vsm_out_port: VSM output port. Words from the internal bus IB are captured
// on LoadOut into a DEPTH-entry FIFO and presented one at a time on Out with
// a valid/acknowledge handshake. Out keeps the last delivered word so that
// consumers ignoring the handshake still see plain output-register behaviour.
//
// Optional build macro VSM_OUT_BYPASS_EN: when defined, a write arriving while
// the port is idle and the FIFO is empty goes straight into Out (1-edge
// latency) instead of passing through the FIFO (2-edge latency).
module vsm_out_port #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             MainClock,
    input  logic             invMainReset,
    input  logic [WIDTH-1:0] IB,
    input  logic             LoadOut,
    input  logic             OutAck,
    input  logic             ClrOvr,
    output logic [WIDTH-1:0] Out,
    output logic             OutValid,
    output logic [CW-1:0]    Count,
    output logic             Full,
    output logic             Empty,
    output logic             Overrun
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt_q;
    logic             pop;
    logic             push;
    logic             drop;
    logic             bypass;

    assign Count    = cnt_q;
    assign Full     = (cnt_q == CNT_FULL);
    assign Empty    = (cnt_q == '0);
    assign OutValid = (state_q == PRESENT);

    // Next-state decode: decides pop, bypass, push acceptance and drops from the pre-edge state
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        bypass  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!Empty) begin
                    pop     = 1'b1;
                    state_d = PRESENT;
                end
`ifdef VSM_OUT_BYPASS_EN
                else if (LoadOut) begin
                    bypass  = 1'b1;
                    state_d = PRESENT;
                end
`endif
            end
            PRESENT: begin
                // OutAck releases the presented word; refill from the FIFO if possible
                if (OutAck) begin
                    if (!Empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A full FIFO still accepts a write when a pop frees the head slot on the same edge
        push = LoadOut && !bypass && (!Full || pop);
        drop = LoadOut && !bypass && Full && !pop;
    end

    // Control state: FSM, pointers, occupancy count and sticky overrun flag
    always_ff @(posedge MainClock or negedge invMainReset) begin
        if (!invMainReset) begin
            state_q <= IDLE;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt_q   <= '0;
            Overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
            // A drop on the same edge takes priority over a clear request
            if (drop) begin
                Overrun <= 1'b1;
            end else if (ClrOvr) begin
                Overrun <= 1'b0;
            end
        end
    end

    // Presented word: loaded from the FIFO head on a pop, or from IB on a bypass write
    always_ff @(posedge MainClock or negedge invMainReset) begin
        if (!invMainReset) begin
            Out <= '0;
        end else if (pop) begin
            Out <= mem[rd_ptr];
        end else if (bypass) begin
            Out <= IB;
        end
    end

    // FIFO storage: data only, contents are don't-care until written
    always_ff @(posedge MainClock) begin
        if (push) begin
            mem[wr_ptr] <= IB;
        end
    end

endmodule

// File: doc/vsm_out_port.md
Name: vsm_out_port

Overview:
Parametrised next-generation VSM output port. It captures WIDTH-bit words from the internal bus IB on LoadOut into a DEPTH-entry FIFO. It presents them one at a time on Out, using a valid/acknowledge handshake toward the external consumer. Out holds the last delivered word indefinitely, preserving the plain output-register semantics for consumers that ignore the handshake.

Parameters:
WIDTH, 4, data width of IB and Out (>=1)
DEPTH, 4, FIFO entries; power of two, >=2
CW, $clog2(DEPTH+1), width of Count (derived, not overridden)

Ports:
MainClock  input  1  system clock; all state changes on the rising edge
invMainReset  input  1  asynchronous active-low reset
IB  input  WIDTH  internal bus data
LoadOut  input  1  write strobe, sampled on the MainClock rising edge
OutAck  input  1  consumer acknowledge, sampled on the rising edge
ClrOvr  input  1  clears the sticky Overrun flag
Out  output  WIDTH  presented data word (registered)
OutValid  output  1  Out holds an unacknowledged word
Count  output  CW  words stored in the FIFO, excluding the word on Out
Full  output  1  Count == DEPTH
Empty  output  1  Count == 0
Overrun  output  1  sticky: a write was dropped

Behaviour:
- Reset (invMainReset=0, asynchronous, takes effect immediately):
  - Out=0, OutValid=0, Count=0, Overrun=0, rd/wr pointers=0, FSM=IDLE.
  - Reset removal is synchronous to MainClock; the first operative edge is the one after deassertion.
- FIFO: circular buffer with log2(DEPTH)-bit pointers that wrap DEPTH-1 -> 0. Full and Empty are decoded combinationally from Count.
- Push: on an edge with LoadOut=1, IB is written at wr_ptr and wr_ptr increments.
  - Push is accepted iff Count<DEPTH, or a pop occurs on the same edge.
  - Otherwise the word is dropped, pointers and Count are unchanged, and Overrun is set.
- Pop: removes the head word into the Out register (see FSM).
- Count update per edge: +1 for push only, -1 for pop only, unchanged for both or neither.
- FSM, two states:
  - IDLE (OutValid=0):
    - If !Empty: pop the head into Out, OutValid<=1, go to PRESENT.
    - Else: stay in IDLE; Out holds its value.
  - PRESENT (OutValid=1):
    - OutAck=0: hold Out and OutValid.
    - OutAck=1 and !Empty: pop the next head into Out, stay in PRESENT (back-to-back, one word per cycle).
    - OutAck=1 and Empty: OutValid<=0, go to IDLE; Out retains the last word.
  - OutAck in IDLE is ignored.
- Latency: LoadOut at edge k into an empty FIFO with the FSM in IDLE -> Out/OutValid updated at edge k+1.
- Simultaneous push and pop with Empty=1: the pop sees the pre-edge state, so there is no pop. The pushed word is presented next cycle.
- Overrun:
  - Set on any dropped write.
  - Cleared by ClrOvr=1 only when no drop occurs on the same edge; a drop wins.
- Capacity: total buffered is DEPTH in the FIFO plus 1 on Out.
- Reset mid-transfer discards all FIFO contents and the presented word.

Optional Feature:
VSM_OUT_BYPASS_EN
- Defined: when the FSM is in IDLE and Empty=1, LoadOut loads IB directly into Out and sets OutValid=1 at the same edge, giving 1-edge latency. Count is unchanged and the FIFO is not written.
- Undefined: every word passes through the FIFO, giving 2-edge latency as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: drive invMainReset=0 mid-cycle with arbitrary state -> immediately Out=0, OutValid=0, Count=0, Empty=1, Overrun=0.
- Single word (WIDTH=4, DEPTH=4): LoadOut with IB=4'hA at edge 1, OutAck=0 -> Count=1 after edge 1; Out=4'hA, OutValid=1, Count=0 after edge 2. OutAck=1 at edge 5 -> OutValid=0, Out stays 4'hA.
- Fill and overrun: OutAck=0, push 1,2,3,4,5,6 on consecutive edges -> Out=1 valid, FIFO holds 2..5, Full=1, word 6 dropped, Overrun=1. ClrOvr pulse -> Overrun=0.
- Full with simultaneous push and ack: state of the previous test, push 7 with OutAck=1 -> Out=2, Count stays 4, Overrun unchanged. Drain with OutAck=1 held -> Out sequence 3,4,5,7 on consecutive edges, then OutValid=0.
- Pointer wrap: 10 push/ack cycles of values 0..9 -> Out sequence exact, no loss, Count never exceeds 1.
- Bypass (macro defined): push 4'h5 into empty IDLE -> Out=5, OutValid=1 after the same edge, Count=0. Without the macro, same stimulus -> OutValid rises one edge later.
